// File: rtl/en_qual_seq_gen.sv
// en_qual_seq_gen: replays a small table of {en, qual, duration} steps onto a
// registered en_out/qual_out pair. Steps with en=1/qual=0 are refused at load
// time, so the outputs always satisfy "en_out implies qual_out".
module en_qual_seq_gen #(
    parameter int DEPTH = 8,
    parameter int DUR_W = 4,
    parameter int REJ_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic                       load_en,
    input  logic                       load_qual,
    input  logic [DUR_W-1:0]           load_dur,
    input  logic                       start,
    input  logic                       loop,
    input  logic                       clear,
    output logic                       en_out,
    output logic                       qual_out,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   step_idx,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [REJ_W-1:0]           reject_cnt
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
    localparam logic [DUR_W-1:0] DUR_ZERO = {DUR_W{1'b0}};
    localparam logic [DUR_W-1:0] DUR_ONE  = {{(DUR_W-1){1'b0}}, 1'b1};
    localparam logic [REJ_W-1:0] REJ_ONE  = {{(REJ_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // A step is storable unless it would drive en without qual.
    function automatic logic step_legal(input logic en_i, input logic qual_i);
        return !(en_i && !qual_i);
    endfunction

    state_t           state_r,  state_nxt_s;
    logic             en_r,     en_nxt_s;
    logic             qual_r,   qual_nxt_s;
    logic             busy_r,   busy_nxt_s;
    logic             done_r,   done_nxt_s;
    logic [IDX_W-1:0] idx_r,    idx_nxt_s;
    logic [CNT_W-1:0] cnt_r,    cnt_nxt_s;
    logic [DUR_W-1:0] dur_r,    dur_nxt_s;
    logic [REJ_W-1:0] rej_r,    rej_nxt_s;

    logic             en_mem_r   [DEPTH];
    logic             qual_mem_r [DEPTH];
    logic [DUR_W-1:0] dur_mem_r  [DEPTH];

    logic             load_ready_s;
    logic             beat_s;
    logic             last_s;
    logic             rej_full_s;
    logic             wr_en_s;
    logic [IDX_W-1:0] idx_inc_s;
    logic [IDX_W-1:0] wr_idx_s;

    assign load_ready_s = (state_r == ST_IDLE) && (cnt_r < CNT_MAX) && !clear;
    assign beat_s       = load_valid && load_ready_s;
    assign last_s       = ({1'b0, idx_r} + CNT_ONE) == cnt_r;
    assign rej_full_s   = &rej_r;
    assign idx_inc_s    = idx_r + IDX_ONE;
    assign wr_idx_s     = cnt_r[IDX_W-1:0];

    assign load_ready = load_ready_s;
    assign en_out     = en_r;
    assign qual_out   = qual_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign step_idx   = idx_r;
    assign count      = cnt_r;
    assign reject_cnt = rej_r;

    // Next-state and next-output decode; clear overrides every other request.
    always_comb begin
        state_nxt_s = state_r;
        en_nxt_s    = en_r;
        qual_nxt_s  = qual_r;
        busy_nxt_s  = busy_r;
        done_nxt_s  = done_r;
        idx_nxt_s   = idx_r;
        cnt_nxt_s   = cnt_r;
        dur_nxt_s   = dur_r;
        rej_nxt_s   = rej_r;
        wr_en_s     = 1'b0;

        if (clear) begin
            state_nxt_s = ST_IDLE;
            en_nxt_s    = 1'b0;
            qual_nxt_s  = 1'b0;
            busy_nxt_s  = 1'b0;
            done_nxt_s  = 1'b0;
            idx_nxt_s   = IDX_ZERO;
            cnt_nxt_s   = CNT_ZERO;
            dur_nxt_s   = DUR_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_nxt_s = 1'b0;
                    if (beat_s) begin
                        if (step_legal(load_en, load_qual)) begin
                            wr_en_s   = 1'b1;
                            cnt_nxt_s = cnt_r + CNT_ONE;
                        end else if (!rej_full_s) begin
                            rej_nxt_s = rej_r + REJ_ONE;
                        end else begin
                            rej_nxt_s = rej_r;
                        end
                    end else begin
                        wr_en_s = 1'b0;
                    end
                    // Step 0 is loaded on the start edge so it is visible next cycle.
                    if (start && (cnt_r != CNT_ZERO)) begin
                        state_nxt_s = ST_PLAY;
                        idx_nxt_s   = IDX_ZERO;
                        en_nxt_s    = en_mem_r[IDX_ZERO];
                        qual_nxt_s  = qual_mem_r[IDX_ZERO];
                        dur_nxt_s   = dur_mem_r[IDX_ZERO];
                        busy_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_PLAY: begin
                    if (dur_r != DUR_ZERO) begin
                        dur_nxt_s = dur_r - DUR_ONE;
                    end else if (!last_s) begin
                        idx_nxt_s  = idx_inc_s;
                        en_nxt_s   = en_mem_r[idx_inc_s];
                        qual_nxt_s = qual_mem_r[idx_inc_s];
                        dur_nxt_s  = dur_mem_r[idx_inc_s];
                    end else if (loop) begin
                        idx_nxt_s  = IDX_ZERO;
                        en_nxt_s   = en_mem_r[IDX_ZERO];
                        qual_nxt_s = qual_mem_r[IDX_ZERO];
                        dur_nxt_s  = dur_mem_r[IDX_ZERO];
                    end else begin
                        state_nxt_s = ST_FIN;
                        en_nxt_s    = 1'b0;
                        qual_nxt_s  = 1'b0;
                        busy_nxt_s  = 1'b0;
                        done_nxt_s  = 1'b1;
                    end
                end
                ST_FIN: begin
                    state_nxt_s = ST_IDLE;
                    done_nxt_s  = 1'b0;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    en_nxt_s    = 1'b0;
                    qual_nxt_s  = 1'b0;
                    busy_nxt_s  = 1'b0;
                    done_nxt_s  = 1'b0;
                    idx_nxt_s   = IDX_ZERO;
                end
            endcase
        end
    end

    // Control and output registers; reset forces the outputs to the safe 0/0 pair.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            en_r    <= 1'b0;
            qual_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            idx_r   <= IDX_ZERO;
            cnt_r   <= CNT_ZERO;
            dur_r   <= DUR_ZERO;
            rej_r   <= {REJ_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            en_r    <= en_nxt_s;
            qual_r  <= qual_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            idx_r   <= idx_nxt_s;
            cnt_r   <= cnt_nxt_s;
            dur_r   <= dur_nxt_s;
            rej_r   <= rej_nxt_s;
        end
    end

    // Step table; only legal steps are ever written, at the current fill level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                en_mem_r[i]   <= 1'b0;
                qual_mem_r[i] <= 1'b0;
                dur_mem_r[i]  <= DUR_ZERO;
            end
        end else if (wr_en_s) begin
            en_mem_r[wr_idx_s]   <= load_en;
            qual_mem_r[wr_idx_s] <= load_qual;
            dur_mem_r[wr_idx_s]  <= load_dur;
        end else begin
            en_mem_r[wr_idx_s]   <= en_mem_r[wr_idx_s];
            qual_mem_r[wr_idx_s] <= qual_mem_r[wr_idx_s];
            dur_mem_r[wr_idx_s]  <= dur_mem_r[wr_idx_s];
        end
    end

endmodule

// File: tb/tb_en_qual_seq_gen.sv
// Directed self-checking bench for en_qual_seq_gen.
module tb_en_qual_seq_gen;

    logic       clk;
    logic       rst;
    logic       load_valid;
    logic       load_ready;
    logic       load_en;
    logic       load_qual;
    logic [3:0] load_dur;
    logic       start;
    logic       loop;
    logic       clear;
    logic       en_out;
    logic       qual_out;
    logic       busy;
    logic       done;
    logic [2:0] step_idx;
    logic [3:0] count;
    logic [7:0] reject_cnt;

    int checks;
    int failures;

    en_qual_seq_gen #(.DEPTH(8), .DUR_W(4), .REJ_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_en    (load_en),
        .load_qual  (load_qual),
        .load_dur   (load_dur),
        .start      (start),
        .loop       (loop),
        .clear      (clear),
        .en_out     (en_out),
        .qual_out   (qual_out),
        .busy       (busy),
        .done       (done),
        .step_idx   (step_idx),
        .count      (count),
        .reject_cnt (reject_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contract watch: en_out must never be high without qual_out.
    always @(negedge clk) begin
        checks++;
        if (en_out && !qual_out) begin
            failures++;
            $display("FAIL invariant en=%0b qual=%0b at %0t", en_out, qual_out, $time);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic e, input logic q, input logic [3:0] d);
        load_valid = 1'b1;
        load_en    = e;
        load_qual  = q;
        load_dur   = d;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        checks++;
        if ({en_out, qual_out, busy, done, step_idx, count, reject_cnt} !== 19'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {en_out, qual_out, busy, done, step_idx, count, reject_cnt});
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (load_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%0b exp=1", load_ready);
        end
    endtask

    task automatic test_basic();
        logic [1:0] exp_eq [6];
        int busy_n;
        int done_n;
        exp_eq = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b00, 2'b00};
        busy_n = 0;
        done_n = 0;
        load(1'b1, 1'b1, 4'd2);
        load(1'b0, 1'b1, 4'd0);
        load(1'b0, 1'b0, 4'd1);
        checks++;
        if (count !== 4'd3) begin
            failures++;
            $display("FAIL basic_count got=%0d exp=3", count);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (i < 6) begin
                if ({en_out, qual_out} !== exp_eq[i]) begin
                    failures++;
                    $display("FAIL basic_eq[%0d] got=%b exp=%b", i, {en_out, qual_out}, exp_eq[i]);
                end
            end else begin
                if ({en_out, qual_out} !== 2'b00) begin
                    failures++;
                    $display("FAIL basic_eq_after[%0d] got=%b exp=00", i, {en_out, qual_out});
                end
            end
            if (i == 6) begin
                checks++;
                if (done !== 1'b1) begin
                    failures++;
                    $display("FAIL basic_done_pos got=%0b exp=1", done);
                end
            end
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) done_n++;
            tick();
        end
        checks++;
        if (busy_n !== 6 || done_n !== 1) begin
            failures++;
            $display("FAIL basic_busy_done got busy=%0d done=%0d exp busy=6 done=1", busy_n, done_n);
        end
        checks++;
        if (count !== 4'd3) begin
            failures++;
            $display("FAIL basic_count_kept got=%0d exp=3", count);
        end
        // A second start replays the retained table.
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({en_out, qual_out, busy, step_idx} !== 6'b111_000) begin
            failures++;
            $display("FAIL basic_replay got=%b exp=111000", {en_out, qual_out, busy, step_idx});
        end
        repeat (10) tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_replay_end busy got=%0b exp=0", busy);
        end
    endtask

    task automatic test_reject();
        do_clear();
        load(1'b1, 1'b0, 4'd0);
        load(1'b1, 1'b1, 4'd0);
        checks++;
        if (reject_cnt !== 8'd1 || count !== 4'd1) begin
            failures++;
            $display("FAIL reject_cnt got rej=%0d cnt=%0d exp rej=1 cnt=1", reject_cnt, count);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({en_out, qual_out, busy} !== 3'b111) begin
            failures++;
            $display("FAIL reject_play got=%b exp=111", {en_out, qual_out, busy});
        end
        tick();
        checks++;
        if ({en_out, qual_out, busy, done} !== 4'b0001) begin
            failures++;
            $display("FAIL reject_fin got=%b exp=0001", {en_out, qual_out, busy, done});
        end
        tick();
    endtask

    task automatic test_full_loop();
        logic en_tab   [8];
        logic qual_tab [8];
        for (int i = 0; i < 8; i++) begin
            en_tab[i]   = (i % 2 == 0);
            qual_tab[i] = (i != 7);
        end
        do_clear();
        for (int i = 0; i < 8; i++) load(en_tab[i], qual_tab[i], 4'd0);
        checks++;
        if (load_ready !== 1'b0 || count !== 4'd8) begin
            failures++;
            $display("FAIL full_ready got rdy=%0b cnt=%0d exp rdy=0 cnt=8", load_ready, count);
        end
        load(1'b1, 1'b1, 4'd0);
        checks++;
        if (count !== 4'd8) begin
            failures++;
            $display("FAIL full_ninth got=%0d exp=8", count);
        end
        loop  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (step_idx !== 3'(k % 8) || {en_out, qual_out, busy} !== {en_tab[k % 8], qual_tab[k % 8], 1'b1}) begin
                failures++;
                $display("FAIL loop_seq[%0d] got idx=%0d eqb=%b exp idx=%0d eqb=%b", k, step_idx,
                         {en_out, qual_out, busy}, k % 8, {en_tab[k % 8], qual_tab[k % 8], 1'b1});
            end
            if (k == 11) loop = 1'b0;
            tick();
        end
        checks++;
        if ({busy, done} !== 2'b01) begin
            failures++;
            $display("FAIL loop_stop got=%b exp=01", {busy, done});
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL loop_done_pulse got=%0b exp=0", done);
        end
    endtask

    task automatic test_clear_mid();
        do_clear();
        load(1'b1, 1'b1, 4'd1);
        load(1'b1, 1'b1, 4'd2);
        load(1'b0, 1'b1, 4'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++;
        if (step_idx !== 3'd1) begin
            failures++;
            $display("FAIL clear_pre_idx got=%0d exp=1", step_idx);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if ({en_out, qual_out, busy, done, step_idx, count, reject_cnt} !== {4'b0000, 3'd0, 4'd0, 8'd1}) begin
            failures++;
            $display("FAIL clear_state got=%h exp=%h", {en_out, qual_out, busy, done, step_idx, count, reject_cnt},
                     {4'b0000, 3'd0, 4'd0, 8'd1});
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({en_out, qual_out, busy} !== 3'b000) begin
            failures++;
            $display("FAIL clear_start_ignored got=%b exp=000", {en_out, qual_out, busy});
        end
    endtask

    task automatic test_async_reset();
        load(1'b1, 1'b1, 4'd15);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({en_out, qual_out, busy} !== 3'b111) begin
            failures++;
            $display("FAIL arst_pre got=%b exp=111", {en_out, qual_out, busy});
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({en_out, qual_out, busy, count} !== 7'd0) begin
            failures++;
            $display("FAIL arst_drop got=%b exp=0000000", {en_out, qual_out, busy, count});
        end
        #2;
        rst = 1'b1;
        tick();
        checks++;
        if ({busy, count, reject_cnt} !== 13'd0) begin
            failures++;
            $display("FAIL arst_release got=%h exp=0", {busy, count, reject_cnt});
        end
    endtask

    task automatic test_saturate();
        load_valid = 1'b1;
        load_en    = 1'b1;
        load_qual  = 1'b0;
        load_dur   = 4'd0;
        repeat (255) tick();
        checks++;
        if (reject_cnt !== 8'd255) begin
            failures++;
            $display("FAIL sat_255 got=%0d exp=255", reject_cnt);
        end
        tick();
        load_valid = 1'b0;
        checks++;
        if (reject_cnt !== 8'd255 || count !== 4'd0) begin
            failures++;
            $display("FAIL sat_hold got rej=%0d cnt=%0d exp rej=255 cnt=0", reject_cnt, count);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b0;
        load_valid = 1'b0;
        load_en    = 1'b0;
        load_qual  = 1'b0;
        load_dur   = 4'd0;
        start      = 1'b0;
        loop       = 1'b0;
        clear      = 1'b0;
        test_reset();
        test_basic();
        test_reject();
        test_full_loop();
        test_clear_mid();
        test_async_reset();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
